// File: rtl/timer_clint.sv
// timer_clint: RISC-V style machine timer (64-bit mtime / mtimecmp) behind a
// simple valid/ready register port. Registers at byte offsets 0x0..0xC from
// timer_base_addr. Accesses outside [timer_base_addr, timer_top_addr) read 0
// and drop their writes.
// Optional feature macro: TIMER_PRESCALE_EN. It divides the mtime tick by
// `prescale` cycles. Without it, mtime ticks every cycle.
module timer_clint #(
   parameter logic [31:0] timer_base_addr = 32'h0020_0000,
   parameter logic [31:0] timer_top_addr  = 32'h0020_0010,
   parameter int unsigned prescale        = 1
) (
   input  logic        reset,
   input  logic        clock,
   input  logic        timer_valid,
   input  logic        timer_instr,
   input  logic [31:0] timer_addr,
   input  logic [31:0] timer_wdata,
   input  logic [3:0]  timer_wstrb,
   output logic [31:0] timer_rdata,
   output logic        timer_ready,
   output logic        timer_irq
);

   logic [31:0] offset;
   logic [1:0]  sel;
   logic        in_range;
   logic        acc_en;
   logic        wr_en;
   logic        tick;

   logic [63:0] mtime_q, mtime_d, mtime_inc;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q;
   logic        irq_q;

   // Replace the bytes of old_v that are selected by strb with new_v.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

   assign offset   = timer_addr - timer_base_addr;
   assign sel      = offset[3:2];
   assign in_range = (timer_addr >= timer_base_addr) && (timer_addr < timer_top_addr);
   assign acc_en   = timer_valid && in_range;
   assign wr_en    = acc_en && (timer_wstrb != '0);

   logic unused_ok;
   assign unused_ok = ^{timer_instr, offset[31:4], offset[1:0]};

`ifdef TIMER_PRESCALE_EN
   // A prescale value of 0 is treated as 1 (tick every cycle).
   localparam int unsigned PS_DIV  = (prescale == 0) ? 1 : prescale;
   localparam logic [31:0] PS_LAST = PS_DIV - 1;

   logic [31:0] pcnt_q;

   assign tick = (pcnt_q == PS_LAST);

   // Prescale counter: counts 0..PS_LAST and wraps, one tick per wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pcnt_q <= '0;
      end else if (tick) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_q + 32'd1;
      end
   end
`else
   logic unused_prescale;
   assign unused_prescale = ^prescale;
   assign tick = 1'b1;
`endif

   assign mtime_inc = mtime_q + 64'd1;

   // Next-state: tick first, then overlay written bytes so a write beats the tick.
   always_comb begin
      mtime_d    = tick ? mtime_inc : mtime_q;
      mtimecmp_d = mtimecmp_q;
      rdata_d    = '0;
      if (acc_en) begin
         case (sel)
            2'd0: rdata_d = mtime_q[31:0];
            2'd1: rdata_d = mtime_q[63:32];
            2'd2: rdata_d = mtimecmp_q[31:0];
            2'd3: rdata_d = mtimecmp_q[63:32];
            default: rdata_d = '0;
         endcase
      end
      if (wr_en) begin
         case (sel)
            2'd0: mtime_d[31:0]     = byte_merge(mtime_d[31:0], timer_wdata, timer_wstrb);
            2'd1: mtime_d[63:32]    = byte_merge(mtime_d[63:32], timer_wdata, timer_wstrb);
            2'd2: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], timer_wdata, timer_wstrb);
            2'd3: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], timer_wdata, timer_wstrb);
            default: ;
         endcase
      end
   end

   // Timer state, response strobe/data and registered interrupt compare.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         rdata_q    <= rdata_d;
         ready_q    <= timer_valid;
         irq_q      <= (mtime_q >= mtimecmp_q);
      end
   end

   assign timer_rdata = rdata_q;
   assign timer_ready = ready_q;
   assign timer_irq   = irq_q;

endmodule

// File: tb/tb_timer_clint.sv
// tb_timer_clint: directed self-checking bench for timer_clint (default build,
// mtime ticks every cycle). Inputs change on the falling edge, outputs are
// sampled on the falling edge. Requests are issued back-to-back, so mtime
// values below are exact cycle counts.
module tb_timer_clint;

   localparam logic [31:0] BASE = 32'h0020_0000;
   localparam logic [31:0] TOP  = 32'h0020_0010;

   logic        clock;
   logic        reset;
   logic        timer_valid;
   logic        timer_instr;
   logic [31:0] timer_addr;
   logic [31:0] timer_wdata;
   logic [3:0]  timer_wstrb;
   logic [31:0] timer_rdata;
   logic        timer_ready;
   logic        timer_irq;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] rd;

   timer_clint #(
      .timer_base_addr(BASE),
      .timer_top_addr (TOP),
      .prescale       (1)
   ) dut (
      .reset      (reset),
      .clock      (clock),
      .timer_valid(timer_valid),
      .timer_instr(timer_instr),
      .timer_addr (timer_addr),
      .timer_wdata(timer_wdata),
      .timer_wstrb(timer_wstrb),
      .timer_rdata(timer_rdata),
      .timer_ready(timer_ready),
      .timer_irq  (timer_irq)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request: drive on a falling edge, registered on the next rising edge,
   // response sampled on the following falling edge (must carry timer_ready).
   task automatic req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata);
      timer_valid = 1'b1;
      timer_addr  = addr;
      timer_wdata = wdata;
      timer_wstrb = strb;
      @(posedge clock);
      @(negedge clock);
      check({tag, "_rdy"}, 64'(timer_ready), 64'd1);
      rdata       = timer_rdata;
      timer_valid = 1'b0;
      timer_wstrb = '0;
      timer_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      timer_valid = 1'b0;
      timer_instr = 1'b0;
      timer_addr  = '0;
      timer_wdata = '0;
      timer_wstrb = '0;
      repeat (3) @(negedge clock);

      // Reset state and first reads of mtimecmp.
      check("rst_ready", 64'(timer_ready), 64'd0);
      check("rst_irq",   64'(timer_irq),   64'd0);
      check("rst_rdata", 64'(timer_rdata), 64'd0);
      reset = 1'b1;
      req("cmp_lo_rst", BASE + 32'h8, '0, 4'b0000, rd);
      check("cmp_lo_rst", 64'(rd), 64'h0000_0000_FFFF_FFFF);
      @(negedge clock);
      check("rdy_idle", 64'(timer_ready), 64'd0);
      check("rdata_idle", 64'(timer_rdata), 64'd0);
      req("cmp_hi_rst", BASE + 32'hC, '0, 4'b0000, rd);
      check("cmp_hi_rst", 64'(rd), 64'h0000_0000_FFFF_FFFF);
      check("irq_after_rst", 64'(timer_irq), 64'd0);

      // Carry from bit 31 into bit 32.
      req("wr_mt_lo", BASE + 32'h0, 32'hFFFF_FFFE, 4'hF, rd);
      req("wr_mt_hi", BASE + 32'h4, 32'h0, 4'hF, rd);
      repeat (2) @(negedge clock);
      req("mt_hi", BASE + 32'h4, '0, 4'h0, rd);
      check("mt_hi_carry", 64'(rd), 64'd1);
      req("mt_lo", BASE + 32'h0, '0, 4'h0, rd);
      check("mt_lo_carry", 64'(rd), 64'd2);

      // Interrupt assertion at mtime == 100 and release on mtimecmp rewrite.
      req("z_mt_hi", BASE + 32'h4, 32'h0, 4'hF, rd);
      req("z_mt_lo", BASE + 32'h0, 32'h0, 4'hF, rd);
      req("cmp_lo100", BASE + 32'h8, 32'd100, 4'hF, rd);
      req("cmp_hi0", BASE + 32'hC, 32'h0, 4'hF, rd);
      repeat (98) @(negedge clock);
      check("irq_pre", 64'(timer_irq), 64'd0);
      @(negedge clock);
      check("irq_rise", 64'(timer_irq), 64'd1);
      req("cmp_lo1000", BASE + 32'h8, 32'd1000, 4'hF, rd);
      check("irq_hold", 64'(timer_irq), 64'd1);
      @(negedge clock);
      check("irq_fall", 64'(timer_irq), 64'd0);
      req("mt_lo_cnt", BASE + 32'h0, '0, 4'h0, rd);
      check("mt_lo_cnt", 64'(rd), 64'd103);

      // Byte-strobe write into mtimecmp low.
      req("cmp_lo_ones", BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, rd);
      req("cmp_lo_strb", BASE + 32'h8, 32'hAABB_CCDD, 4'b0101, rd);
      req("cmp_lo_rd", BASE + 32'h8, '0, 4'h0, rd);
      check("cmp_lo_strb", 64'(rd), 64'h0000_0000_FFBB_FFDD);

      // Out-of-window accesses: respond with 0 and change nothing.
      req("oor_10", BASE + 32'h10, 32'hFFFF_FFF0, 4'hF, rd);
      check("oor_10_rdata", 64'(rd), 64'd0);
      req("oor_18", BASE + 32'h18, 32'h1234_5678, 4'hF, rd);
      check("oor_18_rdata", 64'(rd), 64'd0);
      req("oor_1c", BASE + 32'h1C, 32'h1234_5678, 4'hF, rd);
      req("oor_below", BASE - 32'h4, 32'h1234_5678, 4'hF, rd);
      check("oor_below_rdata", 64'(rd), 64'd0);
      req("oor_10_rd", BASE + 32'h10, '0, 4'h0, rd);
      check("oor_10_rd", 64'(rd), 64'd0);
      req("keep_cmp_lo", BASE + 32'h8, '0, 4'h0, rd);
      check("keep_cmp_lo", 64'(rd), 64'h0000_0000_FFBB_FFDD);
      req("keep_cmp_hi", BASE + 32'hC, '0, 4'h0, rd);
      check("keep_cmp_hi", 64'(rd), 64'd0);
      req("keep_mt_hi", BASE + 32'h4, '0, 4'h0, rd);
      check("keep_mt_hi", 64'(rd), 64'd0);
      req("keep_mt_lo", BASE + 32'h0, '0, 4'h0, rd);
      check("keep_mt_lo", 64'(rd), 64'd115);
      check("irq_low_end", 64'(timer_irq), 64'd0);

      // Reset in the response cycle of a write: response dropped, state cleared.
      timer_valid = 1'b1;
      timer_addr  = BASE + 32'h8;
      timer_wdata = 32'h0000_0055;
      timer_wstrb = 4'hF;
      @(posedge clock);
      #1;
      reset       = 1'b0;
      timer_valid = 1'b0;
      timer_wstrb = '0;
      @(negedge clock);
      check("rdy_in_rst", 64'(timer_ready), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      check("rdy_dropped", 64'(timer_ready), 64'd0);
      check("irq_rst2", 64'(timer_irq), 64'd0);
      req("r2_mt_lo", BASE + 32'h0, '0, 4'h0, rd);
      check("r2_mt_lo", 64'(rd), 64'd0);
      req("r2_mt_hi", BASE + 32'h4, '0, 4'h0, rd);
      check("r2_mt_hi", 64'(rd), 64'd0);
      req("r2_cmp_lo", BASE + 32'h8, '0, 4'h0, rd);
      check("r2_cmp_lo", 64'(rd), 64'h0000_0000_FFFF_FFFF);
      req("r2_cmp_hi", BASE + 32'hC, '0, 4'h0, rd);
      check("r2_cmp_hi", 64'(rd), 64'h0000_0000_FFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/timer_clint.md
TIMER_CLINT -- requirements
Module: timer_clint

Interface
REQ-001 SHALL have parameter timer_base_addr, default 32'h200000, byte address of register 0.
REQ-002 SHALL have parameter timer_top_addr, default 32'h200010, exclusive upper bound of the register window.
REQ-003 SHALL have parameter prescale, default 1, number of clock cycles per mtime tick (used only with TIMER_PRESCALE_EN).
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port timer_valid  input  1  one-cycle request strobe.
REQ-007 SHALL have port timer_instr  input  1  fetch indicator; ignored by this block.
REQ-008 SHALL have port timer_addr  input  32  byte address of the request.
REQ-009 SHALL have port timer_wdata  input  32  write data.
REQ-010 SHALL have port timer_wstrb  input  4  byte write enables; all zero means read.
REQ-011 SHALL have port timer_rdata  output  32  read data, valid while timer_ready is high.
REQ-012 SHALL have port timer_ready  output  1  one-cycle response strobe.
REQ-013 SHALL have port timer_irq  output  1  machine timer interrupt, level.

Function
REQ-014 SHALL hold 64-bit mtime and 64-bit mtimecmp; offsets 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
REQ-015 SHALL decode offset = timer_addr - timer_base_addr, using bits [3:2]; addresses outside [timer_base_addr, timer_top_addr) read 0 and ignore writes.
REQ-016 SHALL register every request with timer_valid high and assert timer_ready exactly one cycle later for one cycle; back-to-back requests every cycle SHALL each get a response.
REQ-017 SHALL return the register value sampled in the request cycle on timer_rdata during the response cycle, else drive 0.
REQ-018 SHALL apply writes byte-wise per timer_wstrb in the request cycle; unselected bytes keep their value.
REQ-019 SHALL increment mtime by 1 per tick as a full 64-bit add, carry from bit 31 into bit 32, wrapping from all-ones to 0.
REQ-020 SHALL, when a write to mtime and a tick coincide, store the written bytes and the incremented value for unwritten bytes; written bytes win.
REQ-021 SHALL drive timer_irq registered: high one cycle after the cycle in which unsigned mtime >= mtimecmp holds, low one cycle after it stops holding.
REQ-022 SHALL compare full 64 bits; a partial mtimecmp update (one word written) SHALL take effect immediately.

Reset
REQ-023 SHALL, on reset low, asynchronously clear mtime to 0, set mtimecmp to all ones, clear timer_ready, timer_rdata, timer_irq and the prescale counter.
REQ-024 SHALL drop any request in flight when reset asserts; no timer_ready is produced for it after release.
REQ-025 SHALL accept requests from the first rising clock edge after reset deasserts.

Configuration
REQ-026 SHALL, with TIMER_PRESCALE_EN defined, tick once every prescale cycles via a counter 0..prescale-1 wrapping to 0; prescale of 0 SHALL behave as 1.
REQ-027 SHALL, without TIMER_PRESCALE_EN, tick every clock cycle and contain no prescale counter.

Verification
REQ-028 SHALL cover: release reset, read 0x8 and 0xC -> both 32'hFFFFFFFF, timer_irq 0, timer_ready exactly one cycle after each timer_valid.
REQ-029 SHALL cover: write mtime low 32'hFFFFFFFE, high 0, then idle 2 ticks -> mtime high reads 1, low reads small count (carry verified).
REQ-030 SHALL cover: mtimecmp high 0, low 100 with mtime near 0 -> timer_irq rises one cycle after mtime reaches 100; writing mtimecmp low 1000 -> timer_irq falls one cycle later.
REQ-031 SHALL cover: write 32'hAABBCCDD to 0x8 with timer_wstrb 4'b0101 over 32'hFFFFFFFF -> reads 32'hFFBBFFDD.
REQ-032 SHALL cover: access address timer_base_addr+0x10 -> timer_ready one cycle later, rdata 0, no register changed.
REQ-033 SHALL cover: reset asserted in the cycle after a write request -> no timer_ready, mtime 0, mtimecmp all ones after release.
